picomips_host_seq: RTL and testbench
====================================

# picomips_host_seq

Host-side handshake sequencer that drives the picoMIPS switch interface and collects its LED result. It is the initiator for the processor's SW/LED protocol. It accepts one 8-bit operand per transaction on a valid/ready command port and presents it on `sw[7:0]`. It then pulses the `sw[8]` handshake for a programmed number of cycles so the processor can run `IN`/compute/`OUT`, and returns the `led` value on a valid/ready response port once the processor has published it. The block sits between a test controller (UART bridge or bench) and the picoMIPS top-level switch/LED pins.

## Interface
- `HOLD_CYCLES`, default 64: cycles `sw[8]` is held high per transaction; legal range 1..255.
- `SETTLE_CYCLES`, default 2: cycles `sw[8]` is held low before `led` is sampled; legal range 2..255.
- `clk` in 1: clock; all logic is rising-edge.
- `n_reset` in 1: reset `n_reset`, asynchronous, active-low; clock `clk`.
- `cmd_valid` in 1: command operand available.
- `cmd_data` in 8: operand to present on `sw[7:0]`.
- `cmd_ready` out 1: high only in IDLE.
- `sw` out 10: `[9]` processor n_reset, `[8]` handshake, `[7:0]` data. All bits are registered.
- `led` in 8: processor LED output.
- `rsp_valid` out 1: response holds the captured LED value.
- `rsp_data` out 8: captured LED value.
- `rsp_ready` in 1: consumer accepts the response.
- `txn_count` out 8: completed transactions, wraps 255→0.

## Operation
- States: IDLE, PRST (macro-only), SETUP, ASSERT, RELEASE, RESP.
- IDLE
  - Drives `cmd_ready`=1, `sw[8]`=0, `sw[7:0]`=0.
  - On `cmd_valid`, latches `cmd_data` into a data register, then goes to PRST (macro on) or SETUP.
- SETUP
  - Lasts exactly 1 cycle.
  - `sw[7:0]`=data, `sw[8]`=0. This guarantees the data is stable before the handshake rises.
- ASSERT
  - `sw[8]`=1 and `sw[7:0]`=data for exactly HOLD_CYCLES cycles, using a down-counter loaded on entry.
- RELEASE
  - `sw[8]`=0 and `sw[7:0]`=data for exactly SETTLE_CYCLES cycles.
  - On the edge that ends the last RELEASE cycle, `rsp_data`<=`led` and `rsp_valid`<=1.
- RESP
  - Holds `rsp_valid`/`rsp_data` until `rsp_valid && rsp_ready`.
  - On that handshake: clears `rsp_valid`, increments `txn_count`, and returns to IDLE. `cmd_ready` is 1 in the next cycle.
- `sw[9]` is 1 in every state except PRST.
- `cmd_valid` outside IDLE is ignored; the command is not consumed.
- `rsp_data` is not altered outside the capture edge.
- `led` is sampled only at the capture edge. Glitches on `led` at any other time are irrelevant.
- Counter loads are saturated to parameter ranges. Out-of-range parameters are a synthesis-time `$error`.

## Timing
- Reset values:
  - `sw`=10'b00_0000_0000, so the processor is held in reset while the host is in reset.
  - `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0, `txn_count`=0, state=IDLE.
- First edge after `n_reset` release: `sw[9]`<=1, `cmd_ready`<=1.
- Accept edge at T (macro off): SETUP occupies T+1.
  - ASSERT spans T+2..T+1+HOLD_CYCLES.
  - RELEASE spans the next SETTLE_CYCLES cycles.
  - `rsp_valid` rises at T+2+HOLD_CYCLES+SETTLE_CYCLES.
  - Default latency is 68 cycles.
- Macro on: PRST adds exactly 2 cycles before SETUP, for a latency of 70 cycles.
- `rsp_ready` held high: RESP lasts 1 cycle. Back-to-back throughput is one transaction per latency+2 cycles.
- `n_reset` asserted mid-transaction: everything returns to reset values immediately.
  - `sw[8]` drops to 0 and `sw[9]` drops to 0 asynchronously.
  - No response is produced and `txn_count` is not incremented.
- SETTLE_CYCLES≥2 is required: the processor copies its OUT register to LED on the first clock with `sw[8]`=0.

## Configuration
- `PICO_HOST_RSTPULSE_EN`
  - Defined: after accept, state PRST drives `sw[9]`=0, `sw[8]`=0, `sw[7:0]`=data for 2 cycles before SETUP. Each transaction therefore restarts the processor from PC 0.
  - Undefined: PRST is absent, `sw[9]` stays 1 after reset, and the processor state persists across transactions.

## Test plan
- Reset: hold `n_reset`=0 for 5 cycles → `sw`=0, `cmd_ready`=0, `rsp_valid`=0. One edge after release → `sw[9]`=1, `cmd_ready`=1.
- Single transaction: `cmd_data`=0x5A with `led` model = input+1 (defaults, macro off) → `sw[7:0]`=0x5A from T+1, `sw[8]`=1 for exactly 64 cycles. `rsp_valid` rises at T+68 with `rsp_data`=0x5B, and `txn_count`=1 after the `rsp_ready` handshake.
- Backpressure: `rsp_ready`=0 for 20 cycles → `rsp_valid`/`rsp_data` stable and `cmd_ready`=0 throughout. A `cmd_valid` pulse with 0x11 during RESP is not consumed.
- Parameter corner: HOLD_CYCLES=1, SETTLE_CYCLES=2, `cmd_data`=0xFF → `sw[8]` high for exactly 1 cycle, `rsp_valid` rises 5 cycles after accept.
- Mid-transaction reset: assert `n_reset` during ASSERT cycle 10 → `sw[8]`=0 and `sw[9]`=0 immediately, no `rsp_valid`, `txn_count` unchanged. The next command completes normally.
- Macro on + wrap: run 256 transactions with `PICO_HOST_RSTPULSE_EN` → `sw[9]` is low exactly 2 cycles per transaction before SETUP, latency is 70, and `txn_count` wraps to 0.

Source files
------------

// File: rtl/picomips_host_seq.sv
// Host sequencer for the picoMIPS SW/LED handshake: present operand, pulse sw[8], capture led.
// Optional per-transaction processor reset pulse (2 cycles of sw[9]=0) under `PICO_HOST_RSTPULSE_EN.
module picomips_host_seq #(
    parameter int HOLD_CYCLES   = 64,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic [9:0] sw,
    input  logic [7:0] led,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       rsp_ready,
    output logic [7:0] txn_count
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("HOLD_CYCLES must be within 1..255");
    end
    if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be within 2..255");
    end

    localparam int HOLD_SAT   = (HOLD_CYCLES < 1) ? 1 : (HOLD_CYCLES > 255) ? 255 : HOLD_CYCLES;
    localparam int SETTLE_SAT = (SETTLE_CYCLES < 2) ? 2 : (SETTLE_CYCLES > 255) ? 255 : SETTLE_CYCLES;
    // Down-counters run to zero inclusive, so load N-1 for N cycles.
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_SAT - 1);
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_SAT - 1);

    typedef enum logic [2:0] {
        IDLE, PRST, SETUP, ASSERT, RELEASE, RESP
    } state_t;

    state_t     state;
    logic [7:0] data;
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            data      <= 8'h00;
            cnt       <= 8'h00;
            sw        <= 10'h000;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            txn_count <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    sw        <= 10'h200;
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        data      <= cmd_data;
                        cmd_ready <= 1'b0;
`ifdef PICO_HOST_RSTPULSE_EN
                        state     <= PRST;
                        sw        <= {2'b00, cmd_data};
                        cnt       <= 8'd1;
`else
                        state     <= SETUP;
                        sw        <= {2'b10, cmd_data};
`endif
                    end
                end
                PRST: begin
                    if (cnt == 8'd0) begin
                        state <= SETUP;
                        sw    <= {2'b10, data};
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                SETUP: begin
                    state <= ASSERT;
                    sw    <= {2'b11, data};
                    cnt   <= HOLD_LD;
                end
                ASSERT: begin
                    if (cnt == 8'd0) begin
                        state <= RELEASE;
                        sw    <= {2'b10, data};
                        cnt   <= SETTLE_LD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RELEASE: begin
                    // The processor publishes LED on the first low-handshake clock; sample at the end.
                    if (cnt == 8'd0) begin
                        rsp_data  <= led;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + 8'd1;
                        cmd_ready <= 1'b1;
                        sw        <= 10'h200;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picomips_host_seq.sv
// Directed bench: reset, single transaction, backpressure, HOLD=1 corner, mid-transaction reset, 256-txn wrap.
module tb_picomips_host_seq;

`ifdef PICO_HOST_RSTPULSE_EN
    localparam int P = 2;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       n_reset;
    logic       cmd_valid, rsp_ready, rsp_valid, cmd_ready;
    logic [7:0] cmd_data, led, rsp_data, txn_count;
    logic [9:0] sw;
    logic       cmd_valid_c, rsp_ready_c, rsp_valid_c, cmd_ready_c;
    logic [7:0] cmd_data_c, led_c, rsp_data_c, txn_count_c;
    logic [9:0] sw_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Processor model: LED = operand + 1
    assign led   = sw[7:0] + 8'd1;
    assign led_c = sw_c[7:0] + 8'd1;

    picomips_host_seq dut (
        .clk(clk), .n_reset(n_reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .sw(sw), .led(led), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_ready(rsp_ready), .txn_count(txn_count)
    );

    picomips_host_seq #(.HOLD_CYCLES(1), .SETTLE_CYCLES(2)) dut_c (
        .clk(clk), .n_reset(n_reset), .cmd_valid(cmd_valid_c), .cmd_data(cmd_data_c),
        .cmd_ready(cmd_ready_c), .sw(sw_c), .led(led_c), .rsp_valid(rsp_valid_c),
        .rsp_data(rsp_data_c), .rsp_ready(rsp_ready_c), .txn_count(txn_count_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command on dut; return cycle index at which rsp_valid is seen
    // (cycle 1 = the cycle after the accept edge), sw[8]-high cycles, sw[9]-low cycles,
    // first sw[8]-high cycle, cycles with wrong sw[7:0], and the captured response.
    task automatic run_txn(input logic [7:0] d, output int lat, output int hi, output int lo9,
                           output int first_hi, output int bad_d, output logic [7:0] rd);
        int w;
        w = 0;
        while (!cmd_ready && w < 10) begin tick(); w++; end
        cmd_valid = 1'b1;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
        lat = 1; hi = 0; lo9 = 0; first_hi = 0; bad_d = 0;
        while (!rsp_valid && lat < 400) begin
            if (sw[8]) begin
                hi++;
                if (first_hi == 0) first_hi = lat;
            end
            if (!sw[9]) lo9++;
            if (sw[7:0] !== d) bad_d++;
            tick();
            lat++;
        end
        rd = rsp_data;
    endtask

    initial begin
        int lat, hi, lo9, first_hi, bad_d, unstable, bad_lat, bad_rsp, lo9_tot, seen;
        logic [7:0] rd;

        n_reset = 1'b0;
        cmd_valid = 1'b0; cmd_data = 8'h00; rsp_ready = 1'b0;
        cmd_valid_c = 1'b0; cmd_data_c = 8'h00; rsp_ready_c = 1'b1;
        repeat (5) tick();
        chk("rst_sw", 32'(sw), 32'h000);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_txn_count", 32'(txn_count), 32'h0);
        n_reset = 1'b1;
        tick();
        chk("post_rst_sw", 32'(sw), 32'h200);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);

        // Single transaction 0x5A, response held back by rsp_ready=0
        run_txn(8'h5A, lat, hi, lo9, first_hi, bad_d, rd);
        chk("single_latency", 32'(lat), 32'(68 + P));
        chk("single_hold", 32'(hi), 32'd64);
        chk("single_first_hi", 32'(first_hi), 32'(2 + P));
        chk("single_sw9_low", 32'(lo9), 32'(P));
        chk("single_sw_data", 32'(bad_d), 32'd0);
        chk("single_rsp_data", 32'(rd), 32'h5B);

        // Backpressure: 20 cycles of rsp_ready=0, with a stray command pulse
        unstable = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 5) begin cmd_valid = 1'b1; cmd_data = 8'h11; end
            if (k == 6) cmd_valid = 1'b0;
            tick();
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h5B || cmd_ready !== 1'b0) unstable++;
        end
        chk("bp_stable", 32'(unstable), 32'd0);
        chk("bp_txn_count_held", 32'(txn_count), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("handshake_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("handshake_txn_count", 32'(txn_count), 32'd1);
        chk("handshake_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("handshake_idle_sw", 32'(sw), 32'h200);
        tick();
        chk("stray_cmd_not_taken", 32'(cmd_ready), 32'h1);

        // HOLD_CYCLES=1 corner on the second instance
        cmd_valid_c = 1'b1; cmd_data_c = 8'hFF;
        tick();
        cmd_valid_c = 1'b0;
        lat = 1; hi = 0;
        while (!rsp_valid_c && lat < 50) begin
            if (sw_c[8]) hi++;
            tick();
            lat++;
        end
        chk("corner_latency", 32'(lat), 32'(5 + P));
        chk("corner_hold", 32'(hi), 32'd1);
        chk("corner_rsp_data", 32'(rsp_data_c), 32'h00);
        tick();
        chk("corner_txn_count", 32'(txn_count_c), 32'd1);

        // Mid-transaction reset during ASSERT cycle 10
        cmd_valid = 1'b1; cmd_data = 8'h33;
        tick();
        cmd_valid = 1'b0;
        repeat (10 + P) tick();
        chk("midrst_in_assert", 32'(sw[8]), 32'h1);
        n_reset = 1'b0;
        #1;
        chk("midrst_async_sw", 32'(sw), 32'h000);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'h0);
        repeat (3) tick();
        n_reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (rsp_valid) seen++;
        end
        chk("midrst_no_rsp", 32'(seen), 32'd0);
        chk("midrst_txn_count", 32'(txn_count), 32'd0);

        rsp_ready = 1'b1;
        run_txn(8'h7E, lat, hi, lo9, first_hi, bad_d, rd);
        chk("after_rst_latency", 32'(lat), 32'(68 + P));
        chk("after_rst_rsp_data", 32'(rd), 32'h7F);
        tick();
        chk("after_rst_txn_count", 32'(txn_count), 32'd1);

        // 255 more transactions: 256 since reset, counter wraps to 0
        bad_lat = 0; bad_rsp = 0; lo9_tot = 0;
        for (int i = 0; i < 255; i++) begin
            run_txn(8'(i), lat, hi, lo9, first_hi, bad_d, rd);
            if (lat != 68 + P || hi != 64 || first_hi != 2 + P || bad_d != 0) bad_lat++;
            if (rd !== 8'(i + 1)) bad_rsp++;
            lo9_tot += lo9;
            tick();
            if (i == 253 && txn_count !== 8'd255) bad_rsp++;
        end
        chk("wrap_timing", 32'(bad_lat), 32'd0);
        chk("wrap_rsp", 32'(bad_rsp), 32'd0);
        chk("wrap_sw9_low_total", 32'(lo9_tot), 32'(255 * P));
        chk("wrap_txn_count", 32'(txn_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
